// File: rtl/data_bus_pkg.sv
// Purpose: shared source codes, destination bit indices and FSM encodings for the data bus sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package data_bus_pkg;

  localparam int DATA_BUS_WIDTH_DEF = 8;
  localparam int N_SRC = 9;
  localparam int N_DST = 12;

  // Bus source codes; 9..15 have no driver.
  typedef enum logic [3:0] {
    SRC_A   = 4'd0,
    SRC_B   = 4'd1,
    SRC_C   = 4'd2,
    SRC_D   = 4'd3,
    SRC_M1  = 4'd4,
    SRC_M2  = 4'd5,
    SRC_X   = 4'd6,
    SRC_Y   = 4'd7,
    SRC_MEM = 4'd8
  } src_e;

  // Destination load-mask bit positions.
  localparam int DST_A    = 0;
  localparam int DST_B    = 1;
  localparam int DST_C    = 2;
  localparam int DST_D    = 3;
  localparam int DST_M1   = 4;
  localparam int DST_M2   = 5;
  localparam int DST_X    = 6;
  localparam int DST_Y    = 7;
  localparam int DST_J1   = 8;
  localparam int DST_J2   = 9;
  localparam int DST_INST = 10;
  localparam int DST_MEM  = 11;

  // FSM encodings, kept as plain constants for older consumers.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_DRIVE   = ST_DRIVE,
    S_LOAD    = ST_LOAD,
    S_RELEASE = ST_RELEASE
  } state_e;

endpackage

// File: rtl/data_bus_src_decode.sv
// Purpose: one-hot driver decode of a source code plus request legality (legality only with BUS_CONTENTION_CHECK_EN).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module data_bus_src_decode
  import data_bus_pkg::*;
(
  input  logic [3:0]       src,
  input  logic [N_DST-1:0] dst,
  output logic [N_SRC-1:0] drive_onehot,
  output logic             illegal
);

  // Codes past MEM have no driver, so they decode to all-zero.
  always_comb begin
    drive_onehot = '0;
    if (src <= SRC_MEM) drive_onehot[src] = 1'b1;
  end

`ifdef BUS_CONTENTION_CHECK_EN
  logic self_load;

  // A register cannot be both the bus driver and a load target in one transfer.
  always_comb begin
    self_load = 1'b0;
    if (src == SRC_MEM)     self_load = dst[DST_MEM];
    else if (src < SRC_MEM) self_load = dst[src[2:0]];
  end

  assign illegal = (src > SRC_MEM) || (dst == '0) || self_load;
`else
  logic unused_dst;
  assign unused_dst = ^dst;
  assign illegal    = 1'b0;
`endif

endmodule

// File: rtl/data_bus_sequencer.sv
// Purpose: sequences one shared-bus transfer: drive source, settle, load destinations, release (BUS_CONTENTION_CHECK_EN adds legality check + sticky err).
// Latency: ack in accept cycle, done SETTLE_CYCLES+2 cycles later; back-to-back period SETTLE_CYCLES+3.
// Backpressure: xfer_ack only in IDLE; a held xfer_req waits until the FSM returns to IDLE.
module data_bus_sequencer
  import data_bus_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = DATA_BUS_WIDTH_DEF,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              xfer_req,
  input  logic [3:0]        xfer_src,
  input  logic [N_DST-1:0]  xfer_dst,
  output logic              xfer_ack,
  output logic              xfer_done,
  output logic              busy,
  output logic [N_SRC-1:0]  drive_en,
  output logic [N_DST-1:0]  load_en,
  output logic              err
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [N_SRC-1:0] cap_drv;
  logic [N_DST-1:0] cap_dst;
  logic [N_SRC-1:0] dec_drv;
  logic             dec_illegal;

  data_bus_src_decode u_decode (
    .src          (xfer_src),
    .dst          (xfer_dst),
    .drive_onehot (dec_drv),
    .illegal      (dec_illegal)
  );

  assign xfer_ack  = (state == ST_IDLE) && xfer_req;
  assign busy      = (state != ST_IDLE);
  assign xfer_done = (state == ST_RELEASE);
  assign drive_en  = ((state == ST_DRIVE) || (state == ST_LOAD)) ? cap_drv : '0;
  assign load_en   = (state == ST_LOAD) ? cap_dst : '0;

  // Transfer FSM; the request is captured at accept so later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cap_drv <= '0;
      cap_dst <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer_req) begin
            cap_drv <= dec_drv;
            cap_dst <= xfer_dst;
            cnt     <= CNT_INIT;
            state   <= dec_illegal ? ST_RELEASE : ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt == '0) state <= ST_LOAD;
          else           cnt   <= cnt - 4'd1;
        end
        ST_LOAD:    state <= ST_RELEASE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

`ifdef BUS_CONTENTION_CHECK_EN
  // Sticky until reset: any accepted illegal request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     err <= 1'b0;
    else if (xfer_ack && dec_illegal) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  // Structural invariants of the bus and the parameter range.
  a_drive_onehot : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(drive_en));
  a_load_only_in_load : assert property (@(posedge clk) disable iff (!reset_n)
    (load_en != '0) |-> (state == ST_LOAD));
  a_params : assert property (@(posedge clk)
    (DATA_BUS_WIDTH > 0) && (SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= 15));

endmodule

// File: doc/data_bus_sequencer.md
DATA_BUS_SEQUENCER -- requirements
Module: data_bus_sequencer

Interface
REQ-001 SHALL have parameter DATA_BUS_WIDTH, default 8, width of the shared data bus being sequenced (documentation/assertion use only).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, number of cycles a source drives the bus before the destination load; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port xfer_req  input  1  transfer request, level.
REQ-006 SHALL have port xfer_src  input  4  source code: A=0, B=1, C=2, D=3, M1=4, M2=5, X=6, Y=7, MEM=8; 9..15 illegal.
REQ-007 SHALL have port xfer_dst  input  12  destination load mask: bits 0..7 = A..Y, 8 = J1, 9 = J2, 10 = INST, 11 = MEM.
REQ-008 SHALL have port xfer_ack  output  1  request accepted this cycle.
REQ-009 SHALL have port xfer_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port drive_en  output  9  one-hot bus driver enable, indexed by source code.
REQ-012 SHALL have port load_en  output  12  destination load strobes, same bit order as xfer_dst.
REQ-013 SHALL have port err  output  1  sticky illegal-request flag.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, LOAD, RELEASE.
REQ-015 IDLE with xfer_req=1: xfer_ack=1 combinationally that cycle, xfer_src/xfer_dst captured, next state DRIVE.
REQ-016 Captured src/dst SHALL be used for the whole transfer; input changes after ack are ignored.
REQ-017 DRIVE: drive_en = one-hot(captured src), load_en=0; lasts exactly SETTLE_CYCLES cycles via down-counter, then LOAD.
REQ-018 LOAD: drive_en held, load_en = captured dst for exactly one cycle, then RELEASE.
REQ-019 RELEASE: drive_en=0, load_en=0, xfer_done=1 for one cycle, then IDLE (guaranteed dead cycle, no bus contention between transfers).
REQ-020 Accept-to-done latency SHALL be SETTLE_CYCLES+2 cycles; next accept earliest in the IDLE cycle following RELEASE.
REQ-021 xfer_req held high continuously SHALL yield back-to-back transfers every SETTLE_CYCLES+3 cycles.
REQ-022 drive_en SHALL never have more than one bit set; load_en SHALL be nonzero only in LOAD.
REQ-023 xfer_ack SHALL be 0 in every state other than IDLE.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE, counter 0, captured src/dst 0, err 0, drive_en 0, load_en 0, busy 0, xfer_done 0.
REQ-025 Reset asserted mid-transfer SHALL abort it with no load_en pulse and no xfer_done; first accept possible on the first clk edge after release.

Configuration
REQ-026 Macro BUS_CONTENTION_CHECK_EN defined: request illegal if src code >8, dst mask zero, or dst includes the source register (src 0..7 vs bit src; src 8 vs bit 11).
REQ-027 With macro, illegal request SHALL be acked, go IDLE->RELEASE directly (no drive_en, no load_en), pulse xfer_done, and set err until reset.
REQ-028 Without macro, err SHALL be tied 0 and every request runs the full sequence; src code >8 yields drive_en=0 throughout.

Structure
REQ-029 Shared package data_bus_pkg SHALL hold the source-code enum, destination bit-index constants, FSM state enum, and DATA_BUS_WIDTH default.
REQ-030 Legality check and one-hot decode SHALL live in sub-module data_bus_src_decode (combinational); FSM and counter in the top.

Verification
REQ-031 SETTLE_CYCLES=2, req src=0 (A), dst=0x400 (INST) -> ack cycle 0; drive_en=0x001 cycles 1-3; load_en=0x400 cycle 3 only; done cycle 4.
REQ-032 req held high, src=8 then src=6 -> two transfers, second ack exactly 5 cycles after first, drive_en never overlapping, zero in both RELEASE cycles.
REQ-033 reset_n low during DRIVE of src=3 -> drive_en=0, busy=0 same cycle; no load_en, no done observed.
REQ-034 With macro, src=2, dst=0x004 -> ack, done 1 cycle later, drive_en/load_en stay 0, err=1 until reset.
REQ-035 Without macro, src=12, dst=0x001 -> full 4-cycle sequence, drive_en=0, load_en=0x001 in LOAD, err=0.
REQ-036 Change xfer_src/xfer_dst every cycle after ack -> drive_en/load_en reflect captured values only.
